// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared state encoding, centroid bound and default widths for the convergence sequencer
package conv_seq_pkg;
  localparam int CENT_IDX_WIDTH_DEF = 3;
  localparam int ITER_WIDTH_DEF = 8;
  localparam int CENT_LAST = 7;
  typedef enum logic [2:0] {IDLE, ARMED, FEED, WAIT_RES, DONE} conv_seq_state_t;
endpackage

// File: rtl/conv_seq_iter_counter.sv
// conv_seq_iter_counter: saturating iteration counter with latched limit; limit compare exists only with CONV_SEQ_MAX_ITER_EN
module conv_seq_iter_counter
  import conv_seq_pkg::*;
#(
  parameter int W = ITER_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
`ifdef CONV_SEQ_MAX_ITER_EN
  input  logic [W-1:0] limit_in,
`endif
  output logic [W-1:0] count,
  output logic         limit_reached
);
  logic [W-1:0] nxt;
  assign nxt = &count ? count : count + 1'b1;
  // count completed iterations, cleared when a job is accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= nxt;
`ifdef CONV_SEQ_MAX_ITER_EN
  logic [W-1:0] limit;
  // latch the limit with the job; it tells whether the incremented count ends the job
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) limit <= '0;
    else if (clr) limit <= limit_in;
  assign limit_reached = |limit && nxt == limit;
`else
  assign limit_reached = 1'b0;
`endif
endmodule

// File: rtl/convergence_sequencer.sv
// convergence_sequencer: sequences one convergence-check pass per k-means iteration (optional limit: CONV_SEQ_MAX_ITER_EN)
module convergence_sequencer
  import conv_seq_pkg::*;
#(
  parameter int CENT_IDX_WIDTH = CENT_IDX_WIDTH_DEF,
  parameter int ITER_WIDTH = ITER_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      job_start,
  input  logic                      abort,
`ifdef CONV_SEQ_MAX_ITER_EN
  input  logic [ITER_WIDTH-1:0]     max_iter,
`endif
  input  logic                      iter_start,
  input  logic                      mean_valid,
  output logic                      mean_ready,
  output logic [CENT_IDX_WIDTH-1:0] cent_num,
  output logic                      convergence_reg_en,
  output logic                      convergence_regs_reset_n,
  input  logic                      has_converged,
  input  logic                      converge_res_available,
  output logic                      cent_wr_en,
  output logic [CENT_IDX_WIDTH-1:0] cent_wr_idx,
  output logic                      iter_done,
  output logic                      job_done,
  output logic                      converged,
  output logic                      limit_hit,
  output logic [ITER_WIDTH-1:0]     iter_count,
  output logic                      busy
);
  conv_seq_state_t state, nxt;
  logic [CENT_IDX_WIDTH-1:0] idx;
  logic last, fire, job_accept, res_take, limit_reached;
  assign last = idx == CENT_IDX_WIDTH'(CENT_LAST);
  assign fire = mean_valid & mean_ready;
  assign convergence_reg_en = fire;
  assign job_accept = job_start & ~abort & (state == IDLE || state == ARMED || state == DONE);
  assign res_take = converge_res_available & ~abort & state == WAIT_RES;
  assign job_done = state == DONE;
  conv_seq_iter_counter #(.W(ITER_WIDTH)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .clr(job_accept),
    .inc(res_take),
`ifdef CONV_SEQ_MAX_ITER_EN
    .limit_in(max_iter),
`endif
    .count(iter_count),
    .limit_reached(limit_reached)
  );
  // next state and datapath controls; index 7 is masked to 0 while stalled so the datapath cannot finish early
  always_comb begin
    nxt = state;
    mean_ready = 1'b0;
    cent_num = '0;
    convergence_regs_reset_n = 1'b0;
    busy = 1'b0;
    case (state)
      IDLE: if (job_start) nxt = ARMED;
      ARMED: if (!job_start && iter_start) nxt = FEED;
      FEED: begin
        mean_ready = 1'b1;
        convergence_regs_reset_n = 1'b1;
        busy = 1'b1;
        cent_num = last && !mean_valid ? '0 : idx;
        if (last && mean_valid) nxt = WAIT_RES;
      end
      WAIT_RES: begin
        convergence_regs_reset_n = 1'b1;
        busy = 1'b1;
        if (converge_res_available) nxt = has_converged || limit_reached ? DONE : ARMED;
      end
      DONE: if (job_start) nxt = ARMED;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // centroid index advances on each handshake and restarts at 0 outside FEED
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx <= '0;
    else idx <= state == FEED ? idx + CENT_IDX_WIDTH'(fire) : '0;
  // writeback strobe trails each handshake by one cycle to align with the registered centroid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cent_wr_en <= 1'b0;
      cent_wr_idx <= '0;
    end else begin
      cent_wr_en <= fire;
      cent_wr_idx <= idx;
    end
  // registered job status and pass-complete pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      converged <= 1'b0;
      limit_hit <= 1'b0;
      iter_done <= 1'b0;
    end else begin
      converged <= abort || job_accept ? 1'b0 : res_take && has_converged ? 1'b1 : converged;
      limit_hit <= abort || job_accept ? 1'b0 : res_take && !has_converged && limit_reached ? 1'b1 : limit_hit;
      iter_done <= res_take;
    end
endmodule
